c_bus_demux_regbank: RTL and testbench
======================================

Name: c_bus_demux_regbank

Overview:
- Write-side counterpart of the B-bus source mux.
- Takes the ALU result on C_bus and a 3-bit destination code, and registers it into PC, DR or R1–R5 on the clock edge.
- Also performs PC/loop-register increments and memory-to-DR loads.
- Its register outputs are the source operands that the B-bus mux selects from.

Parameters:
- WIDTH, 16, data width of C_bus, mem_data and every register.
- PC_RST, 0, value loaded into PC on reset.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
- c_flag  input  3  destination code: 0=PC, 1=DR, 2=R1, 3=R2, 4=R3, 5=R4, 6=R5, 7=no write
- c_wr  input  1  C-bus write strobe; write happens only when high and c_flag != 7
- C_bus  input  WIDTH  data to be written
- dr_load  input  1  load DR from mem_data
- mem_data  input  WIDTH  memory read data
- inc_pc  input  1  PC <= PC+1
- inc_r1  input  1  R1 <= R1+1
- inc_r2  input  1  R2 <= R2+1
- inc_r3  input  1  R3 <= R3+1
- PC, DR, R1, R2, R3, R4, R5  output  WIDTH each  registered contents
- wr_done  output  1  one-cycle pulse, high the cycle after any C-bus write or DR load commits

Behaviour:
- Reset (rst_n low at rising edge):
  - PC=PC_RST; DR=R1=R2=R3=R4=R5=0; wr_done=0.
  - Overrides every other input in that cycle.
  - Reset asserted mid-sequence discards any same-cycle write or increment.
- Latency: one cycle. Values on C_bus/mem_data at edge N are visible on the outputs after edge N. No combinational path from any input to any output.
- Per-register next-value priority, highest first:
  - DR: dr_load (mem_data) > C-bus write (c_wr && c_flag==1) > hold.
  - PC: C-bus write (c_flag==0) > inc_pc > hold.
  - R1/R2/R3: C-bus write (c_flag==2/3/4) > inc_r1/inc_r2/inc_r3 > hold.
  - R4/R5: C-bus write (c_flag==5/6) > hold.
- Destination decode and concurrency:
  - Decode is exclusive; at most one register takes C_bus per cycle.
  - Increments on other registers proceed in parallel with the write.
- Increment arithmetic: modulo 2^WIDTH; all-ones wraps to 0, with no carry or flag.
- c_flag==7 with c_wr=1: no register changes from the C bus; wr_done stays 0 unless dr_load is also high.
- Simultaneous dr_load and a C-bus write to DR: mem_data wins; wr_done=1.
- Simultaneous dr_load and a C-bus write to another register: both commit.
- wr_done: registered OR of (c_wr && c_flag!=7) and dr_load. Increments alone never set it.
- X/undefined c_flag is not legal; the outputs hold in that case.

Optional Feature:
- Macro: CREG_LAST_DEST_EN.
- Defined:
  - Adds output last_dest[2:0].
  - Holds the c_flag of the most recent committed C-bus write; a DR load records 1.
  - Reset value is 7.
  - Unchanged on cycles with no commit.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset: rst_n=0 one edge with c_wr=1, c_flag=2, C_bus=16'h1234 → PC=0, R1=0, all regs 0, wr_done=0.
- Each destination: c_wr=1, c_flag=0..6 with C_bus=16'hA000+code → only the addressed register updates, one cycle later; the other six hold; wr_done pulses once per write; c_flag=7 changes nothing and wr_done=0.
- Priority and wrap:
  - PC=16'hFFFF, inc_pc=1 → PC=0.
  - Then c_wr=1, c_flag=0, C_bus=16'h0040 with inc_pc=1 → PC=16'h0040, not 16'h0041.
- DR conflict:
  - dr_load=1, mem_data=16'h00FF together with c_wr=1, c_flag=1, C_bus=16'h1111 → DR=16'h00FF, wr_done=1.
  - Next cycle, idle inputs → wr_done=0.
- Parallel ops: R1=5, R2=9; inc_r1=inc_r2=inc_r3=1 plus a C-bus write to R5 (16'h0077) → R1=6, R2=10, R3=1, R5=16'h0077, wr_done=1.
- CREG_LAST_DEST_EN build:
  - After reset, last_dest=7.
  - Write to R3 (c_flag=4) → last_dest=4; an increment-only cycle keeps 4.
  - dr_load → last_dest=1.

Source files
------------

// File: rtl/c_bus_demux_regbank.sv
// c_bus_demux_regbank
//   Write-side register bank fed by the ALU result on C_bus. A 3-bit
//   destination code steers C_bus into PC, DR or R1-R5 on the rising clock
//   edge. The bank also performs PC/R1/R2/R3 increments and memory-to-DR
//   loads. The register outputs are the operands that the B-bus mux reads.
//
// Parameters
//   WIDTH   data width of C_bus, mem_data and every register
//   PC_RST  value loaded into PC on reset
//
// Ports
//   clk            system clock, rising edge
//   rst_n          synchronous active-low reset, overrides all other inputs
//   c_flag[2:0]    destination: 0=PC 1=DR 2=R1 3=R2 4=R3 5=R4 6=R5 7=none
//   c_wr           C-bus write strobe
//   C_bus          write data
//   dr_load        load DR from mem_data (beats a C-bus write to DR)
//   mem_data       memory read data
//   inc_pc/inc_r1/inc_r2/inc_r3   increment requests (lose to a C-bus write)
//   PC, DR, R1..R5 registered contents
//   wr_done        one-cycle pulse after any C-bus write or DR load commits
//   last_dest[2:0] (only with CREG_LAST_DEST_EN) destination of the most
//                  recent commit; a DR load records 1; reset value 7
//
// Optional feature macro: CREG_LAST_DEST_EN

module c_bus_demux_regbank #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] PC_RST = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       c_flag,
  input  logic             c_wr,
  input  logic [WIDTH-1:0] C_bus,
  input  logic             dr_load,
  input  logic [WIDTH-1:0] mem_data,
  input  logic             inc_pc,
  input  logic             inc_r1,
  input  logic             inc_r2,
  input  logic             inc_r3,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] DR,
  output logic [WIDTH-1:0] R1,
  output logic [WIDTH-1:0] R2,
  output logic [WIDTH-1:0] R3,
  output logic [WIDTH-1:0] R4,
  output logic [WIDTH-1:0] R5,
  output logic             wr_done
`ifdef CREG_LAST_DEST_EN
  ,
  output logic [2:0]       last_dest
`endif
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] r_pc, r_dr, r_r1, r_r2, r_r3, r_r4, r_r5;
  logic             r_wr_done;
  logic [6:0]       w_sel;      // one-hot destination, bit i = code i
  logic             w_wr_any;

  // Exclusive destination decode; an illegal/X code selects nothing.
  always_comb begin
    w_sel = 7'b000_0000;
    if (c_wr) begin
      case (c_flag)
        3'd0:    w_sel = 7'b000_0001;
        3'd1:    w_sel = 7'b000_0010;
        3'd2:    w_sel = 7'b000_0100;
        3'd3:    w_sel = 7'b000_1000;
        3'd4:    w_sel = 7'b001_0000;
        3'd5:    w_sel = 7'b010_0000;
        3'd6:    w_sel = 7'b100_0000;
        default: w_sel = 7'b000_0000;
      endcase
    end else begin
      w_sel = 7'b000_0000;
    end
  end

  assign w_wr_any = |w_sel;

  // PC: C-bus write > increment > hold.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_pc <= PC_RST;
    else if (w_sel[0]) r_pc <= C_bus;
    else if (inc_pc)   r_pc <= r_pc + ONE;
    else               r_pc <= r_pc;
  end

  // DR: memory load wins over a C-bus write.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_dr <= ZERO;
    else if (dr_load)  r_dr <= mem_data;
    else if (w_sel[1]) r_dr <= C_bus;
    else               r_dr <= r_dr;
  end

  // R1..R3: C-bus write > increment > hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r1 <= ZERO;
      r_r2 <= ZERO;
      r_r3 <= ZERO;
    end else begin
      if (w_sel[2])    r_r1 <= C_bus;
      else if (inc_r1) r_r1 <= r_r1 + ONE;
      else             r_r1 <= r_r1;
      if (w_sel[3])    r_r2 <= C_bus;
      else if (inc_r2) r_r2 <= r_r2 + ONE;
      else             r_r2 <= r_r2;
      if (w_sel[4])    r_r3 <= C_bus;
      else if (inc_r3) r_r3 <= r_r3 + ONE;
      else             r_r3 <= r_r3;
    end
  end

  // R4/R5: C-bus write only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_r4 <= ZERO;
      r_r5 <= ZERO;
    end else begin
      r_r4 <= w_sel[5] ? C_bus : r_r4;
      r_r5 <= w_sel[6] ? C_bus : r_r5;
    end
  end

  // Commit pulse: any C-bus write or DR load; increments never count.
  always_ff @(posedge clk) begin
    if (!rst_n) r_wr_done <= 1'b0;
    else        r_wr_done <= w_wr_any | dr_load;
  end

`ifdef CREG_LAST_DEST_EN
  logic [2:0] r_last_dest;

  // Destination of the latest commit; a DR load is recorded as code 1 and
  // takes precedence when it coincides with a write elsewhere.
  always_ff @(posedge clk) begin
    if (!rst_n)        r_last_dest <= 3'd7;
    else if (dr_load)  r_last_dest <= 3'd1;
    else if (w_wr_any) r_last_dest <= c_flag;
    else               r_last_dest <= r_last_dest;
  end

  assign last_dest = r_last_dest;
`endif

  assign PC      = r_pc;
  assign DR      = r_dr;
  assign R1      = r_r1;
  assign R2      = r_r2;
  assign R3      = r_r3;
  assign R4      = r_r4;
  assign R5      = r_r5;
  assign wr_done = r_wr_done;

endmodule

// File: tb/tb_c_bus_demux_regbank.sv
module tb_c_bus_demux_regbank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  c_flag;
  logic        c_wr;
  logic [15:0] c_bus;
  logic        dr_load;
  logic [15:0] mem_data;
  logic        inc_pc, inc_r1, inc_r2, inc_r3;
  logic [15:0] pc, dr, r1, r2, r3, r4, r5;
  logic        wr_done;
`ifdef CREG_LAST_DEST_EN
  logic [2:0]  last_dest;
`endif

  int total = 0;
  int bad   = 0;

  // expected register contents, index = destination code
  logic [15:0] m [0:6];

  always #5 clk = ~clk;

  c_bus_demux_regbank #(.WIDTH(16), .PC_RST(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .c_flag(c_flag), .c_wr(c_wr), .C_bus(c_bus),
    .dr_load(dr_load), .mem_data(mem_data), .inc_pc(inc_pc), .inc_r1(inc_r1),
    .inc_r2(inc_r2), .inc_r3(inc_r3), .PC(pc), .DR(dr), .R1(r1), .R2(r2),
    .R3(r3), .R4(r4), .R5(r5), .wr_done(wr_done)
`ifdef CREG_LAST_DEST_EN
    , .last_dest(last_dest)
`endif
  );

  task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dut_reg(input int i);
    case (i)
      0: return pc;
      1: return dr;
      2: return r1;
      3: return r2;
      4: return r3;
      5: return r4;
      default: return r5;
    endcase
  endfunction

  task automatic check_all(input string tag, input logic exp_done);
    for (int i = 0; i < 7; i++)
      check_val($sformatf("%s_reg%0d", tag, i), dut_reg(i), m[i]);
    check_val({tag, "_wr_done"}, {15'd0, wr_done}, {15'd0, exp_done});
  endtask

  task automatic check_ld(input string tag, input logic [2:0] exp);
`ifdef CREG_LAST_DEST_EN
    check_val({tag, "_last_dest"}, {13'd0, last_dest}, {13'd0, exp});
`endif
  endtask

  task automatic idle();
    rst_n = 1'b1; c_wr = 1'b0; c_flag = 3'd7; c_bus = 16'h0000;
    dr_load = 1'b0; mem_data = 16'h0000;
    inc_pc = 1'b0; inc_r1 = 1'b0; inc_r2 = 1'b0; inc_r3 = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] code, input logic [15:0] val);
    idle();
    c_wr = 1'b1; c_flag = code; c_bus = val;
  endtask

  initial begin
    idle();
    // reset with a conflicting write present
    rst_n = 1'b0; c_wr = 1'b1; c_flag = 3'd2; c_bus = 16'h1234; inc_pc = 1'b1;
    step();
    for (int i = 0; i < 7; i++) m[i] = 16'h0000;
    check_all("reset", 1'b0);
    check_ld("reset", 3'd7);

    // each destination, then an idle cycle to close the pulse
    for (int code = 0; code < 7; code++) begin
      wr(code[2:0], 16'hA000 + code[15:0]);
      step();
      m[code] = 16'hA000 + code[15:0];
      check_all($sformatf("dest%0d", code), 1'b1);
      check_ld($sformatf("dest%0d", code), code[2:0]);
      idle();
      step();
      check_all($sformatf("dest%0d_idle", code), 1'b0);
    end

    // code 7 writes nothing
    wr(3'd7, 16'hDEAD);
    step();
    check_all("nodest", 1'b0);
    check_ld("nodest", 3'd6);

    // PC wrap then write-over-increment priority
    wr(3'd0, 16'hFFFF);
    step();
    m[0] = 16'hFFFF;
    check_all("pc_ffff", 1'b1);
    idle(); inc_pc = 1'b1;
    step();
    m[0] = 16'h0000;
    check_all("pc_wrap", 1'b0);
    wr(3'd0, 16'h0040); inc_pc = 1'b1;
    step();
    m[0] = 16'h0040;
    check_all("pc_prio", 1'b1);

    // DR conflict: memory load wins
    wr(3'd1, 16'h1111); dr_load = 1'b1; mem_data = 16'h00FF;
    step();
    m[1] = 16'h00FF;
    check_all("dr_conflict", 1'b1);
    check_ld("dr_conflict", 3'd1);
    idle();
    step();
    check_all("dr_after", 1'b0);

    // code 7 write alongside a DR load still pulses
    wr(3'd7, 16'h2222); dr_load = 1'b1; mem_data = 16'hBEEF;
    step();
    m[1] = 16'hBEEF;
    check_all("nodest_load", 1'b1);

    // setup for parallel ops
    wr(3'd2, 16'h0005); step(); m[2] = 16'h0005;
    wr(3'd3, 16'h0009); step(); m[3] = 16'h0009;
    wr(3'd4, 16'h0000); step(); m[4] = 16'h0000;
    check_all("par_setup", 1'b1);
    check_ld("r3_write", 3'd4);
    idle(); inc_pc = 1'b1;
    step();
    m[0] = 16'h0041;
    check_all("inc_only", 1'b0);
    check_ld("inc_only", 3'd4);

    // increments in parallel with a write to R5
    wr(3'd6, 16'h0077); inc_r1 = 1'b1; inc_r2 = 1'b1; inc_r3 = 1'b1;
    step();
    m[2] = 16'h0006; m[3] = 16'h000A; m[4] = 16'h0001; m[6] = 16'h0077;
    check_all("parallel", 1'b1);

    // DR load alone, concurrent with a write to R4
    wr(3'd5, 16'h0123); dr_load = 1'b1; mem_data = 16'h5A5A;
    step();
    m[1] = 16'h5A5A; m[5] = 16'h0123;
    check_all("load_and_r4", 1'b1);
    check_ld("load_and_r4", 3'd1);

    // reset mid-sequence discards same-cycle write and increments
    wr(3'd5, 16'h9999); inc_pc = 1'b1; inc_r1 = 1'b1; dr_load = 1'b1;
    mem_data = 16'h7777; rst_n = 1'b0;
    step();
    for (int i = 0; i < 7; i++) m[i] = 16'h0000;
    check_all("mid_reset", 1'b0);
    check_ld("mid_reset", 3'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
